// File: rtl/mul_shift_add.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement.
// Works on magnitudes and applies the sign once at the end; can stop early when the multiplier runs out of set bits.
module mul_shift_add #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand, mplier, mplier_sh;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, addend;
  logic                 neg, last;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign abs_a = (signed_mode & a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign abs_b = (signed_mode & b[WIDTH-1]) ? (~b + 1'b1) : b;

  assign busy = (state != IDLE);

  always_comb begin
    mplier_sh = mplier >> 1;
    addend    = {{WIDTH{1'b0}}, mcand} << cnt;
    last      = (cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplier_sh == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand  <= abs_a;
          mplier <= abs_b;
          neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + addend;
          mplier <= mplier_sh;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          // a zero magnitude negates to zero, so neg needs no special case
          product <= neg ? (~acc + 1'b1) : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shift_add.sv
// Directed bench for mul_shift_add: one instance with EARLY_EXIT=0 and one with EARLY_EXIT=1
// share the inputs; products, done latency, busy and handshake corners are checked.
module tb_mul_shift_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [15:0] a, b;
  logic        busy0, done0, busy1, done1;
  logic [31:0] product0, product1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_shift_add #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy0), .done(done0), .product(product0)
  );

  mul_shift_add #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1), .product(product1)
  );

  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          lat1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launches one op and watches 20 cycles; optionally pulses start (other operands) at cycle g_at.
  task automatic run_op(input logic sm, input logic [15:0] a_i, input logic [15:0] b_i,
                        input int g_at,
                        output int lat0, output int lat1,
                        output logic [31:0] p0, output logic [31:0] p1,
                        output int nd0, output int nd1,
                        output logic bz0, output logic bz1);
    lat0 = 0; lat1 = 0; p0 = '0; p1 = '0; nd0 = 0; nd1 = 0; bz0 = 1'b1; bz1 = 1'b1;
    @(negedge clk);
    signed_mode = sm; a = a_i; b = b_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (g_at != 0 && k == g_at) begin
        start = 1'b1; a = 16'h0007; b = 16'h0007;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done0) begin
        nd0++;
        if (lat0 == 0) begin lat0 = k; p0 = product0; bz0 = busy0; end
      end
      if (done1) begin
        nd1++;
        if (lat1 == 0) begin lat1 = k; p1 = product1; bz1 = busy1; end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int          l0, l1, n0, n1;
    logic [31:0] p0, p1;
    logic        b0, b1;
    int          t0[2], t1[2];
    int          c0, c1;
    logic [31:0] q0, q1;

    vecs[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17};
    vecs[1]  = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 4};
    vecs[2]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 17};
    vecs[3]  = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 2};
    vecs[4]  = '{1'b0, 16'h1234, 16'h0000, 32'h00000000, 2};
    vecs[5]  = '{1'b0, 16'h1234, 16'h8000, 32'h091A0000, 17};
    vecs[6]  = '{1'b1, 16'h0000, 16'hFFFF, 32'h00000000, 2};
    vecs[7]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 2};
    vecs[8]  = '{1'b0, 16'h00FF, 16'h0010, 32'h00000FF0, 6};
    vecs[9]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 17};
    vecs[10] = '{1'b0, 16'h8000, 16'h0001, 32'h00008000, 2};
    vecs[11] = '{1'b1, 16'h0003, 16'hFFF9, 32'hFFFFFFEB, 4};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy0", {63'd0, busy0}, 64'd0);
    chk("reset done1", {63'd0, done1}, 64'd0);
    chk("reset product0", {32'd0, product0}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle busy1", {63'd0, busy1}, 64'd0);
    chk("idle product1", {32'd0, product1}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sm, vecs[i].a, vecs[i].b, 0, l0, l1, p0, p1, n0, n1, b0, b1);
      chk($sformatf("v%0d product ee0", i), {32'd0, p0}, {32'd0, vecs[i].p});
      chk($sformatf("v%0d product ee1", i), {32'd0, p1}, {32'd0, vecs[i].p});
      chk($sformatf("v%0d latency ee0", i), 64'(l0), 64'd17);
      chk($sformatf("v%0d latency ee1", i), 64'(l1), 64'(vecs[i].lat1));
      chk($sformatf("v%0d done count", i), 64'(n0 * 10 + n1), 64'd11);
      chk($sformatf("v%0d busy at done", i), {62'd0, b0, b1}, 64'd0);
    end

    // start pulsed mid-RUN with other operands must be ignored
    run_op(1'b0, 16'h0003, 16'hFFFF, 5, l0, l1, p0, p1, n0, n1, b0, b1);
    chk("midrun product ee0", {32'd0, p0}, 64'h2FFFD);
    chk("midrun product ee1", {32'd0, p1}, 64'h2FFFD);
    chk("midrun latency ee1", 64'(l1), 64'd17);
    chk("midrun done count", 64'(n0 * 10 + n1), 64'd11);

    // start held high: each unit re-accepts right after its done cycle
    t0 = '{0, 0}; t1 = '{0, 0}; c0 = 0; c1 = 0; q0 = '0; q1 = '0;
    @(negedge clk);
    signed_mode = 1'b0; a = 16'h0003; b = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done0) begin if (c0 < 2) t0[c0] = k; c0++; q0 = product0; end
      if (done1) begin if (c1 < 2) t1[c1] = k; c1++; q1 = product1; end
    end
    start = 1'b0;
    chk("b2b first ee1", 64'(t1[0]), 64'd4);
    chk("b2b gap ee1", 64'(t1[1] - t1[0]), 64'd5);
    chk("b2b first ee0", 64'(t0[0]), 64'd17);
    chk("b2b gap ee0", 64'(t0[1] - t0[0]), 64'd18);
    chk("b2b product", {q0, q1}, {32'h0000000F, 32'h0000000F});
    repeat (25) @(posedge clk);

    // reset five cycles into a full-length op
    @(negedge clk);
    signed_mode = 1'b0; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst busy", {62'd0, busy0, busy1}, 64'd0);
    chk("rst done", {62'd0, done0, done1}, 64'd0);
    chk("rst product", {product0, product1}, 64'd0);
    @(negedge clk); rst = 1'b0;
    c0 = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy0 || busy1) c0++;
    end
    chk("post rst quiet", 64'(c0), 64'd0);
    run_op(1'b1, 16'hFFFD, 16'h0005, 0, l0, l1, p0, p1, n0, n1, b0, b1);
    chk("post rst product", {p0, p1}, {32'hFFFFFFF1, 32'hFFFFFFF1});
    chk("post rst latency", 64'(l0 * 100 + l1), 64'd1704);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
